// File: rtl/time_set_if.sv
// Button/timekeeper bundle between the debouncers, the time-set controller and the counter block.
// master drives the button and current-time inputs; slave is the controller.
interface time_set_if;
    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;

    logic              tick;
    logic              mode_pulse;
    logic              up_pulse;
    logic              up_held;
    logic              down_pulse;
    logic              down_held;
    logic [HOUR_W-1:0] cur_hour;
    logic [MIN_W-1:0]  cur_min;
    logic [HOUR_W-1:0] set_hour;
    logic [MIN_W-1:0]  set_min;
    logic              load;
    logic              setting;
    logic [1:0]        state;

    modport master (
        output tick, mode_pulse, up_pulse, up_held, down_pulse, down_held,
        output cur_hour, cur_min,
        input  set_hour, set_min, load, setting, state
    );

    modport slave (
        input  tick, mode_pulse, up_pulse, up_held, down_pulse, down_held,
        input  cur_hour, cur_min,
        output set_hour, set_min, load, setting, state
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting session controller: RUN / SET_HOUR / SET_MIN with wrap-around editing,
// press-and-hold auto-repeat, inactivity abort and a one-cycle load strobe on completion.
module time_set_ctrl #(
    parameter int unsigned DELAY_TICKS   = 500,
    parameter int unsigned RATE_TICKS    = 100,
    parameter int unsigned TIMEOUT_TICKS = 10000,
    parameter int unsigned CNT_W         = 16
) (
    input logic        clk,
    input logic        rst_n,
    time_set_if.slave  bus
);
    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    typedef enum logic {
        PH_DELAY = 1'b0,
        PH_RATE  = 1'b1
    } phase_t;

    state_t            st_q;
    phase_t            phase_q;
    logic [CNT_W-1:0]  rpt_cnt_q;
    logic [CNT_W-1:0]  to_cnt_q;
    logic [HOUR_W-1:0] hour_q;
    logic [MIN_W-1:0]  min_q;
    logic              load_q;
    logic              setting_q;

    logic              in_set_c;
    logic              rpt_run_c;
    logic              fire_c;
    logic              step_up_c;
    logic              step_dn_c;
    logic              do_up_c;
    logic              do_dn_c;
    logic              activity_c;
    logic              timeout_c;
    logic [HOUR_W-1:0] hour_inc_c;
    logic [HOUR_W-1:0] hour_dec_c;
    logic [MIN_W-1:0]  min_inc_c;
    logic [MIN_W-1:0]  min_dec_c;

    // Step, repeat-fire and timeout decode from the current registered state.
    always_comb begin
        in_set_c   = (st_q != ST_RUN);
        // Repeat counts only with exactly one button held and no fresh press this cycle.
        rpt_run_c  = in_set_c && !bus.up_pulse && !bus.down_pulse &&
                     (bus.up_held ^ bus.down_held);
        fire_c     = 1'b0;
        if (rpt_run_c && bus.tick) begin
            if (phase_q == PH_DELAY) begin
                fire_c = (rpt_cnt_q == CNT_W'(DELAY_TICKS - 1));
            end else begin
                fire_c = (rpt_cnt_q == CNT_W'(RATE_TICKS - 1));
            end
        end
        step_up_c  = in_set_c && (bus.up_pulse   || (fire_c && bus.up_held));
        step_dn_c  = in_set_c && (bus.down_pulse || (fire_c && bus.down_held));
        // Opposing steps cancel; a mode press discards any step.
        do_up_c    = step_up_c && !step_dn_c && !bus.mode_pulse;
        do_dn_c    = step_dn_c && !step_up_c && !bus.mode_pulse;
        activity_c = bus.mode_pulse || bus.up_pulse || bus.down_pulse ||
                     bus.up_held || bus.down_held || step_up_c || step_dn_c;
        timeout_c  = in_set_c && !activity_c && bus.tick &&
                     (to_cnt_q == CNT_W'(TIMEOUT_TICKS - 1));
        hour_inc_c = (hour_q == HOUR_W'(23)) ? '0 : hour_q + HOUR_W'(1);
        hour_dec_c = (hour_q == '0) ? HOUR_W'(23) : hour_q - HOUR_W'(1);
        min_inc_c  = (min_q == MIN_W'(59)) ? '0 : min_q + MIN_W'(1);
        min_dec_c  = (min_q == '0) ? MIN_W'(59) : min_q - MIN_W'(1);
    end

    // Session FSM, edited values, repeat and timeout counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= ST_RUN;
            phase_q   <= PH_DELAY;
            rpt_cnt_q <= '0;
            to_cnt_q  <= '0;
            hour_q    <= '0;
            min_q     <= '0;
            load_q    <= 1'b0;
            setting_q <= 1'b0;
        end else begin
            load_q <= 1'b0;

            if (!rpt_run_c) begin
                rpt_cnt_q <= '0;
                phase_q   <= PH_DELAY;
            end else if (bus.tick) begin
                if (fire_c) begin
                    rpt_cnt_q <= '0;
                    phase_q   <= PH_RATE;
                end else begin
                    rpt_cnt_q <= rpt_cnt_q + CNT_W'(1);
                end
            end

            if (!in_set_c || activity_c || timeout_c) begin
                to_cnt_q <= '0;
            end else if (bus.tick) begin
                to_cnt_q <= to_cnt_q + CNT_W'(1);
            end

            case (st_q)
                ST_RUN: begin
                    if (bus.mode_pulse) begin
                        st_q      <= ST_SET_HOUR;
                        setting_q <= 1'b1;
                        hour_q    <= bus.cur_hour;
                        min_q     <= bus.cur_min;
                    end
                end
                ST_SET_HOUR: begin
                    if (bus.mode_pulse) begin
                        st_q <= ST_SET_MIN;
                    end else if (timeout_c) begin
                        st_q      <= ST_RUN;
                        setting_q <= 1'b0;
                    end else if (do_up_c) begin
                        hour_q <= hour_inc_c;
                    end else if (do_dn_c) begin
                        hour_q <= hour_dec_c;
                    end
                end
                ST_SET_MIN: begin
                    if (bus.mode_pulse) begin
                        st_q      <= ST_RUN;
                        setting_q <= 1'b0;
                        load_q    <= 1'b1;
                    end else if (timeout_c) begin
                        st_q      <= ST_RUN;
                        setting_q <= 1'b0;
                    end else if (do_up_c) begin
                        min_q <= min_inc_c;
                    end else if (do_dn_c) begin
                        min_q <= min_dec_c;
                    end
                end
                default: begin
                    st_q      <= ST_RUN;
                    setting_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state    = 2'(st_q);
    assign bus.setting  = setting_q;
    assign bus.set_hour = hour_q;
    assign bus.set_min  = min_q;
    assign bus.load     = load_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: capture, wrap, auto-repeat, load strobe, timeout and reset.
module tb_time_set_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks    = 0;
    int   errors    = 0;
    int   load_seen = 0;

    time_set_if bus ();

    time_set_ctrl #(
        .DELAY_TICKS   (500),
        .RATE_TICKS    (100),
        .TIMEOUT_TICKS (10000),
        .CNT_W         (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.load === 1'b1) load_seen++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        bus.tick = 1'b1;
        cyc(n);
        bus.tick = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press_up();
        bus.up_pulse = 1'b1;
        cyc(1);
        bus.up_pulse = 1'b0;
        cyc(1);
    endtask

    task automatic press_down();
        bus.down_pulse = 1'b1;
        cyc(1);
        bus.down_pulse = 1'b0;
        cyc(1);
    endtask

    task automatic press_mode();
        bus.mode_pulse = 1'b1;
        cyc(1);
        bus.mode_pulse = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.tick       = 1'b0;
        bus.mode_pulse = 1'b0;
        bus.up_pulse   = 1'b0;
        bus.up_held    = 1'b0;
        bus.down_pulse = 1'b0;
        bus.down_held  = 1'b0;
        bus.cur_hour   = 5'd14;
        bus.cur_min    = 6'd37;
        cyc(3);
        check("rst_state",   32'(bus.state),    0);
        check("rst_setting", 32'(bus.setting),  0);
        check("rst_hour",    32'(bus.set_hour), 0);
        check("rst_min",     32'(bus.set_min),  0);
        check("rst_load",    32'(bus.load),     0);
        rst_n = 1'b1;
        cyc(2);

        // Enter SET_HOUR and capture the running time.
        press_mode();
        check("enter_state",   32'(bus.state),    1);
        check("enter_setting", 32'(bus.setting),  1);
        check("enter_hour",    32'(bus.set_hour), 14);
        check("enter_min",     32'(bus.set_min),  37);
        cyc(1);

        // Hour wrap at 23.
        for (int i = 0; i < 9; i++) press_up();
        check("hour_to_23", 32'(bus.set_hour), 23);
        press_up();
        check("hour_wrap_up", 32'(bus.set_hour), 0);
        press_down();
        check("hour_wrap_dn", 32'(bus.set_hour), 23);

        // mode + up in the same cycle: transition wins, hour unchanged.
        bus.mode_pulse = 1'b1;
        bus.up_pulse   = 1'b1;
        cyc(1);
        bus.mode_pulse = 1'b0;
        bus.up_pulse   = 1'b0;
        check("mode_up_state", 32'(bus.state),    2);
        check("mode_up_hour",  32'(bus.set_hour), 23);
        cyc(1);

        // Minute wrap at 0.
        for (int i = 0; i < 37; i++) press_down();
        check("min_to_0", 32'(bus.set_min), 0);
        press_down();
        check("min_wrap_dn", 32'(bus.set_min), 59);
        press_up();
        check("min_wrap_up", 32'(bus.set_min), 0);
        for (int i = 0; i < 10; i++) press_up();
        check("min_to_10", 32'(bus.set_min), 10);

        // Opposing pulses cancel.
        bus.up_pulse   = 1'b1;
        bus.down_pulse = 1'b1;
        cyc(1);
        bus.up_pulse   = 1'b0;
        bus.down_pulse = 1'b0;
        check("up_dn_cancel", 32'(bus.set_min), 10);
        cyc(1);

        // Press and hold up: repeats at 500, 600, 700, 800 ticks.
        bus.up_held  = 1'b1;
        bus.up_pulse = 1'b1;
        cyc(1);
        bus.up_pulse = 1'b0;
        check("hold_press", 32'(bus.set_min), 11);
        ticks(499);
        check("hold_499", 32'(bus.set_min), 11);
        ticks(1);
        check("hold_500", 32'(bus.set_min), 12);
        ticks(99);
        check("hold_599", 32'(bus.set_min), 12);
        ticks(1);
        check("hold_600", 32'(bus.set_min), 13);
        ticks(100);
        check("hold_700", 32'(bus.set_min), 14);
        ticks(100);
        check("hold_800", 32'(bus.set_min), 15);
        bus.up_held = 1'b0;
        cyc(1);
        ticks(300);
        check("release", 32'(bus.set_min), 15);

        // up_pulse with both held: pulse steps, no repeat.
        bus.up_held   = 1'b1;
        bus.down_held = 1'b1;
        bus.up_pulse  = 1'b1;
        cyc(1);
        bus.up_pulse  = 1'b0;
        check("both_pulse", 32'(bus.set_min), 16);
        ticks(600);
        check("both_held", 32'(bus.set_min), 16);
        check("both_state", 32'(bus.state), 2);
        bus.up_held   = 1'b0;
        bus.down_held = 1'b0;
        cyc(1);

        // Commit: load for exactly one cycle with the edited values.
        check("preload_seen", 32'(load_seen), 0);
        press_mode();
        check("commit_state",   32'(bus.state),    0);
        check("commit_load",    32'(bus.load),     1);
        check("commit_setting", 32'(bus.setting),  0);
        check("commit_hour",    32'(bus.set_hour), 23);
        check("commit_min",     32'(bus.set_min),  16);
        cyc(1);
        check("load_drop", 32'(bus.load), 0);
        check("load_once", 32'(load_seen), 1);

        // Buttons ignored in RUN.
        press_up();
        bus.up_held = 1'b1;
        ticks(600);
        bus.up_held = 1'b0;
        cyc(1);
        check("run_ignore_min", 32'(bus.set_min), 16);
        check("run_state",      32'(bus.state),   0);

        // Timeout, restarted by a press just before expiry.
        press_mode();
        check("to_enter", 32'(bus.set_hour), 14);
        cyc(1);
        ticks(9999);
        check("to_9999", 32'(bus.state), 1);
        press_down();
        check("to_press", 32'(bus.set_hour), 13);
        ticks(9999);
        check("to_restart", 32'(bus.state), 1);
        ticks(1);
        check("to_state",   32'(bus.state),   0);
        check("to_setting", 32'(bus.setting), 0);
        cyc(1);
        check("to_noload", 32'(load_seen), 1);

        // Reset in the middle of an auto-repeat.
        press_mode();
        cyc(1);
        bus.up_held  = 1'b1;
        bus.up_pulse = 1'b1;
        cyc(1);
        bus.up_pulse = 1'b0;
        check("mid_press", 32'(bus.set_hour), 15);
        ticks(550);
        check("mid_repeat", 32'(bus.set_hour), 16);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state",   32'(bus.state),    0);
        check("arst_setting", 32'(bus.setting),  0);
        check("arst_hour",    32'(bus.set_hour), 0);
        check("arst_load",    32'(bus.load),     0);
        bus.up_held = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        check("post_rst_state", 32'(bus.state), 0);
        check("post_rst_load",  32'(load_seen), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
